stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
// - Command sequencer for one STACK instance (head reg + shifting tail) in the tok core.
// - Accepts stack ops over a valid/ready handshake; drives the STACK we/delta/wd strobes.
// - Tracks occupancy and flags overflow/underflow; composite ops (SWAP, OVER) run as 3-step sequences.
// - Sits between decode/execute and the data or return STACK.
// PARAMETERS
// - DEPTH  8  tail entries of the controlled STACK; capacity CAP = DEPTH+1 (head + tail)
// - WIDTH  8  data width; matches the STACK
// - CW     $clog2(DEPTH+2)  occupancy counter width (localparam)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - cmd_valid  in   1      command present
// - cmd_ready  out  1      controller can accept (idle)
// - cmd_op     in   3      opcode (see BEHAVIOUR)
// - cmd_data   in   WIDTH  operand for PUSH/REPL
// - top        in   WIDTH  STACK rd (current head value)
// - stk_we     out  1      STACK we
// - stk_delta  out  2      STACK delta: [1]=pop(1)/push(0), [0]=move
// - stk_wd     out  WIDTH  STACK wd
// - depth      out  CW     entries held, 0..CAP
// - empty      out  1      depth==0
// - full       out  1      depth==CAP
// - err        out  1      sticky error; cleared by rst or err_clr
// - err_code   out  2      1=underflow 2=overflow 3=bad opcode; holds first error
// - err_clr    in   1      clears err/err_code next edge
// BEHAVIOUR
// - Reset: depth=0, err=0, err_code=0, FSM=IDLE, cmd_ready=1, strobes idle (we=0, delta=00, wd=0).
//   STACK contents are not reset; depth=0 defines them as dead. Reset mid-sequence aborts it
//   (partial STACK writes allowed; they are dead data).
// - Opcodes / strobes. Step 0 is Mealy, in the accept cycle N (cmd_valid & cmd_ready):
//   0 NOP : none                                         depth+0
//   1 PUSH: we=1 delta=01 wd=cmd_data                    depth+1, needs depth<CAP
//   2 POP : we=0 delta=11                                depth-1, needs depth>=1
//   3 REPL: we=1 delta=00 wd=cmd_data                    depth+0, needs depth>=1
//   4 DUP : we=1 delta=01 wd=top                         depth+1, needs 1<=depth<CAP
//   5 SWAP: N: T<=top, pop; N+1: U<=top, we wd=T delta=00; N+2: push wd=U       depth+0, needs depth>=2
//   6 OVER: N: T<=top, pop; N+1: push wd=T;              N+2: push wd=U(=top at N+1)  depth+1, needs 2<=depth<CAP
//   7 reserved: bad opcode
// - OVER step N+1 also latches U<=top before the push.
// - FSM: IDLE -> S1 -> S2 -> IDLE for SWAP/OVER; all other ops stay in IDLE.
//   cmd_ready=1 only in IDLE, so single-step ops sustain 1 op/cycle. Composite ops
//   deassert ready during N+1 and N+2; ready returns in N+3.
// - depth updates once, at the accept edge, by the net delta; empty/full follow from depth.
// - Precondition fail or bad opcode: command is consumed, no strobes issued, depth unchanged,
//   FSM stays IDLE. Sets err, and sets err_code only if err was 0. Underflow is checked before overflow.
// - err_clr and a new error in the same cycle: the new error wins.
// - cmd_data and cmd_op are sampled only in the accept cycle; T and U are internal WIDTH-bit regs.
// STRUCTURE
// - Package stack_ctrl_pkg: op enum (NOP..OVER), err_code enum, DELTA_* constants
//   (PUSH=2'b01, POP=2'b11, HOLD=2'b00).
// - No sub-module; STACK is instantiated beside this block by the parent (core / bench).
// TESTING (bench wires stack_ctrl to a real STACK, DEPTH=4, WIDTH=8, CAP=5)
// - After rst: PUSH 0x11, 0x22, 0x33 back-to-back -> top=0x33, depth=3, ready held 1 throughout.
// - SWAP on [.. 0x22, 0x33]: ready low 2 cycles -> top=0x22, next=0x33 (check by POP), depth=3.
// - OVER on [0x11, 0x22] -> stack [0x11, 0x22, 0x11], depth=3; consecutive POPs read 0x11, 0x22, 0x11.
// - Fill to 5, then PUSH 0x44 -> err=1, code=2, depth=5, top unchanged, no we/move pulse.
// - Empty stack: POP -> err=1, code=1; then opcode 7 -> code stays 1; err_clr -> err=0, code=0.
// - rst asserted in S1 of SWAP -> next cycle depth=0, empty=1, ready=1, strobes idle.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared types and strobe encodings for the STACK command sequencer.
package stack_ctrl_pkg;

  // Command opcodes; encoding 3'd7 is reserved and reported as a bad opcode.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_REPL = 3'd3,
    OP_DUP  = 3'd4,
    OP_SWAP = 3'd5,
    OP_OVER = 3'd6
  } op_e;

  // Error codes reported on err_code; only the first error since the last clear is held.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_BADOP = 2'd3
  } err_e;

  // Sequencer states: composite ops walk IDLE -> S1 -> S2 -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2
  } state_e;

  // STACK delta strobes: bit 1 selects pop(1)/push(0), bit 0 enables the move.
  localparam logic [1:0] DELTA_HOLD = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;

endpackage

// File: rtl/stack_ctrl.sv
// Command sequencer for one STACK (head register + shifting tail).
// Single-step ops issue their strobes in the accept cycle; SWAP and OVER
// run as three-step sequences using two scratch registers T and U.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] top,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr
);

  // Capacity counts the head register plus every tail entry.
  localparam logic [CW-1:0] CAP = CW'(DEPTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);

  state_e           state, state_nxt;
  logic             is_over_q, is_over_nxt;
  logic [WIDTH-1:0] t_q, u_q;
  logic             load_t, load_u;
  logic [CW-1:0]    depth_q, depth_nxt;
  logic             err_q;
  err_e             err_code_q;
  logic             accept;
  err_e             chk;

  // Precondition check for an opcode against the current occupancy.
  // Underflow is tested first so an op that could fail both ways reports underflow.
  function automatic err_e check_op(input logic [2:0] op, input logic [CW-1:0] d);
    err_e r;
    r = ERR_NONE;
    case (op)
      OP_NOP:  r = ERR_NONE;
      OP_PUSH: r = (d == CAP) ? ERR_OVER : ERR_NONE;
      OP_POP:  r = (d == '0) ? ERR_UNDER : ERR_NONE;
      OP_REPL: r = (d == '0) ? ERR_UNDER : ERR_NONE;
      OP_DUP:  r = (d == '0) ? ERR_UNDER : ((d == CAP) ? ERR_OVER : ERR_NONE);
      OP_SWAP: r = (d < TWO) ? ERR_UNDER : ERR_NONE;
      OP_OVER: r = (d < TWO) ? ERR_UNDER : ((d == CAP) ? ERR_OVER : ERR_NONE);
      default: r = ERR_BADOP;
    endcase
    return r;
  endfunction

  // Next-state, Mealy strobes and occupancy update.
  always_comb begin
    state_nxt   = state;
    is_over_nxt = is_over_q;
    cmd_ready   = (state == ST_IDLE);
    stk_we      = 1'b0;
    stk_delta   = DELTA_HOLD;
    stk_wd      = '0;
    load_t      = 1'b0;
    load_u      = 1'b0;
    depth_nxt   = depth_q;
    accept      = cmd_valid && (state == ST_IDLE);
    chk         = check_op(cmd_op, depth_q);

    case (state)
      ST_IDLE: begin
        if (accept && (chk == ERR_NONE)) begin
          case (cmd_op)
            OP_PUSH: begin
              stk_we    = 1'b1;
              stk_delta = DELTA_PUSH;
              stk_wd    = cmd_data;
              depth_nxt = depth_q + ONE;
            end
            OP_POP: begin
              stk_delta = DELTA_POP;
              depth_nxt = depth_q - ONE;
            end
            OP_REPL: begin
              stk_we = 1'b1;
              stk_wd = cmd_data;
            end
            OP_DUP: begin
              stk_we    = 1'b1;
              stk_delta = DELTA_PUSH;
              stk_wd    = top;
              depth_nxt = depth_q + ONE;
            end
            OP_SWAP: begin
              load_t      = 1'b1;
              stk_delta   = DELTA_POP;
              is_over_nxt = 1'b0;
              state_nxt   = ST_S1;
            end
            OP_OVER: begin
              load_t      = 1'b1;
              stk_delta   = DELTA_POP;
              is_over_nxt = 1'b1;
              depth_nxt   = depth_q + ONE;
              state_nxt   = ST_S1;
            end
            default: ;
          endcase
        end
      end
      ST_S1: begin
        // The pop in step 0 exposed the second entry on top; keep it as U.
        // SWAP overwrites the head with T, OVER pushes T above it.
        load_u    = 1'b1;
        stk_we    = 1'b1;
        stk_wd    = t_q;
        stk_delta = is_over_q ? DELTA_PUSH : DELTA_HOLD;
        state_nxt = ST_S2;
      end
      ST_S2: begin
        stk_we    = 1'b1;
        stk_wd    = u_q;
        stk_delta = DELTA_PUSH;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, composite-op kind and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      is_over_q <= 1'b0;
      depth_q   <= '0;
    end else begin
      state     <= state_nxt;
      is_over_q <= is_over_nxt;
      depth_q   <= depth_nxt;
    end
  end

  // Scratch operands for composite ops; contents are only meaningful mid-sequence.
  always_ff @(posedge clk) begin
    if (load_t) t_q <= top;
    if (load_u) u_q <= top;
  end

  // Sticky error flag; a new error beats a same-cycle clear, and a clear in
  // the same cycle lets the new error's code replace the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (accept && (chk != ERR_NONE)) begin
      err_q <= 1'b1;
      if (!err_q || err_clr) err_code_q <= chk;
    end else if (err_clr) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end
  end

  assign depth    = depth_q;
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == CAP);
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl driving a behavioural head+tail STACK, with a
// queue-based reference model checked every cycle plus directed literal checks.
module tb_stack_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 2);
  localparam int CAP   = DEPTH + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] top;
  logic             stk_we;
  logic [1:0]       stk_delta;
  logic [WIDTH-1:0] stk_wd;
  logic [CW-1:0]    depth;
  logic             empty, full, err;
  logic [1:0]       err_code;
  logic             err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .top(top), .stk_we(stk_we),
    .stk_delta(stk_delta), .stk_wd(stk_wd), .depth(depth), .empty(empty),
    .full(full), .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  // Behavioural STACK: head register with a shifting tail underneath.
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail [DEPTH];
  assign top = head;

  always @(posedge clk) begin
    if (stk_delta[0] && stk_delta[1]) begin
      head <= stk_we ? stk_wd : tail[0];
      for (int i = 0; i < DEPTH - 1; i++) tail[i] <= tail[i+1];
    end else if (stk_delta[0]) begin
      head    <= stk_we ? stk_wd : head;
      tail[0] <= head;
      for (int i = 1; i < DEPTH; i++) tail[i] <= tail[i-1];
    end else if (stk_we) begin
      head <= stk_wd;
    end
  end

  // Reference model: stack as a queue (back = top), busy cycles for composites.
  logic [WIDTH-1:0] mq [$];
  bit               m_err = 1'b0;
  int               m_code = 0;
  int               m_busy = 0;

  function automatic int exp_code(input logic [2:0] op, input int sz);
    case (op)
      3'd0:       return 0;
      3'd1:       return (sz == CAP) ? 2 : 0;
      3'd2, 3'd3: return (sz == 0) ? 1 : 0;
      3'd4:       return (sz == 0) ? 1 : ((sz == CAP) ? 2 : 0);
      3'd5:       return (sz < 2) ? 1 : 0;
      3'd6:       return (sz < 2) ? 1 : ((sz == CAP) ? 2 : 0);
      default:    return 3;
    endcase
  endfunction

  // Model update on each rising edge from the inputs presented in that cycle.
  always @(posedge clk) begin
    int c;
    logic [WIDTH-1:0] tmp;
    if (rst) begin
      mq.delete();
      m_err  = 1'b0;
      m_code = 0;
      m_busy = 0;
    end else if (cmd_valid && m_busy == 0) begin
      c = exp_code(cmd_op, mq.size());
      if (c != 0) begin
        if (!m_err || err_clr) m_code = c;
        m_err = 1'b1;
      end else begin
        if (err_clr) begin m_err = 1'b0; m_code = 0; end
        case (cmd_op)
          3'd1: mq.push_back(cmd_data);
          3'd2: void'(mq.pop_back());
          3'd3: mq[mq.size()-1] = cmd_data;
          3'd4: mq.push_back(mq[mq.size()-1]);
          3'd5: begin
            tmp = mq[mq.size()-1];
            mq[mq.size()-1] = mq[mq.size()-2];
            mq[mq.size()-2] = tmp;
            m_busy = 2;
          end
          3'd6: begin
            mq.push_back(mq[mq.size()-2]);
            m_busy = 2;
          end
          default: ;
        endcase
      end
    end else begin
      if (m_busy > 0) m_busy = m_busy - 1;
      if (err_clr) begin m_err = 1'b0; m_code = 0; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_depth", 32'(depth), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full",  32'(full),  32'(mq.size() == CAP));
      chk("m_err",   32'(err),   32'(m_err));
      chk("m_code",  32'(err_code), 32'(m_code));
      chk("m_ready", 32'(cmd_ready), 32'(m_busy == 0));
      if (m_busy == 0 && mq.size() > 0)
        chk("m_top", 32'(top), 32'(mq[mq.size()-1]));
      if (!rst && cmd_valid && m_busy == 0 && exp_code(cmd_op, mq.size()) != 0) begin
        chk("m_err_we",    32'(stk_we),    32'd0);
        chk("m_err_delta", 32'(stk_delta), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("ready_timeout", 32'(n < 10), 32'd1);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_code",  32'(err_code), 32'd0);
    chk("rst_strobe", {21'd0, stk_we, stk_delta, stk_wd}, 32'd0);

    // Back-to-back pushes with ready held high.
    chk("push_rdy1", 32'(cmd_ready), 32'd1); issue(3'd1, 8'h11);
    chk("push_rdy2", 32'(cmd_ready), 32'd1); issue(3'd1, 8'h22);
    chk("push_rdy3", 32'(cmd_ready), 32'd1); issue(3'd1, 8'h33);
    chk("push_top", 32'(top), 32'h33);
    chk("push_depth", 32'(depth), 32'd3);

    // SWAP: ready low for two cycles, then top and next exchanged.
    issue(3'd5, 8'h00);
    chk("swap_rdy_s1", 32'(cmd_ready), 32'd0); step();
    chk("swap_rdy_s2", 32'(cmd_ready), 32'd0); step();
    chk("swap_rdy_back", 32'(cmd_ready), 32'd1);
    chk("swap_top", 32'(top), 32'h22);
    chk("swap_depth", 32'(depth), 32'd3);
    issue(3'd2, 8'h00);
    chk("swap_next", 32'(top), 32'h33);

    // Rebuild [0x11, 0x22] and run OVER.
    issue(3'd2, 8'h00);
    issue(3'd1, 8'h22);
    issue(3'd6, 8'h00);
    wait_ready();
    chk("over_depth", 32'(depth), 32'd3);
    chk("over_pop1", 32'(top), 32'h11); issue(3'd2, 8'h00);
    chk("over_pop2", 32'(top), 32'h22); issue(3'd2, 8'h00);
    chk("over_pop3", 32'(top), 32'h11); issue(3'd2, 8'h00);
    chk("over_empty", 32'(empty), 32'd1);

    // DUP and REPL.
    issue(3'd1, 8'h5a);
    issue(3'd4, 8'h00);
    chk("dup_depth", 32'(depth), 32'd2);
    chk("dup_top", 32'(top), 32'h5a);
    issue(3'd3, 8'ha5);
    chk("repl_top", 32'(top), 32'ha5);
    chk("repl_depth", 32'(depth), 32'd2);
    issue(3'd2, 8'h00);
    chk("repl_under", 32'(top), 32'h5a);
    issue(3'd2, 8'h00);

    // Fill to capacity, then overflow.
    for (int i = 1; i <= CAP; i++) issue(3'd1, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h44;
    #1;
    chk("ovf_we", 32'(stk_we), 32'd0);
    chk("ovf_delta", 32'(stk_delta), 32'd0);
    step();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_code", 32'(err_code), 32'd2);
    chk("ovf_depth", 32'(depth), 32'd5);
    chk("ovf_top", 32'(top), 32'h05);

    // Clear, drain, underflow, then bad opcode keeps the first code.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr1_err", 32'(err), 32'd0);
    for (int i = 0; i < CAP; i++) issue(3'd2, 8'h00);
    chk("drain_empty", 32'(empty), 32'd1);
    issue(3'd2, 8'h00);
    chk("unf_err", 32'(err), 32'd1);
    chk("unf_code", 32'(err_code), 32'd1);
    chk("unf_depth", 32'(depth), 32'd0);
    issue(3'd7, 8'h00);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_code_held", 32'(err_code), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("clr2_err", 32'(err), 32'd0);
    chk("clr2_code", 32'(err_code), 32'd0);

    // Reset while SWAP is in S1.
    issue(3'd1, 8'h11);
    issue(3'd1, 8'h22);
    issue(3'd1, 8'h33);
    issue(3'd5, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_strobe", {21'd0, stk_we, stk_delta, stk_wd}, 32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
